// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for the immediate generator: instruction/pc in,
// decoded immediate, format, branch target and illegal flag out.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm_out;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
    logic            illegal;

    modport master (
        output in_valid, instruction, pc, out_ready,
        input  in_ready, out_valid, imm_out, fmt, target, illegal
    );

    modport slave (
        input  in_valid, instruction, pc, out_ready,
        output in_ready, out_valid, imm_out, fmt, target, illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV immediate generator with one registered output stage (XLEN 32/64).
// Optional statistics counters under IMM_GEN_PIPE_STATS_EN.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input logic clk,
    input logic rst,
    imm_gen_pipe_if.slave bus
`ifdef IMM_GEN_PIPE_STATS_EN
    ,
    output logic [31:0] decoded_count,
    output logic [15:0] illegal_count
`endif
);
    typedef enum logic [2:0] {
        F_NONE = 3'd0,
        F_I    = 3'd1,
        F_S    = 3'd2,
        F_B    = 3'd3,
        F_U    = 3'd4,
        F_J    = 3'd5,
        F_Z    = 3'd6
    } fmt_e;

    localparam bit IS64 = (XLEN == 64);

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_REG32 = 7'b0111011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    logic [31:0]     ins;
    logic [6:0]      op;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_z;

    assign ins = bus.instruction;
    assign op  = ins[6:0];
    assign f3  = ins[14:12];

    always_comb begin
        imm_i = XLEN'($signed(ins[31:20]));
        imm_s = XLEN'($signed({ins[31:25], ins[11:7]}));
        imm_b = XLEN'($signed({ins[31], ins[7], ins[30:25],
                               ins[11:8], 1'b0}));
        imm_u = XLEN'($signed({ins[31:12], 12'b0}));
        imm_j = XLEN'($signed({ins[31], ins[19:12], ins[20],
                               ins[30:21], 1'b0}));
        imm_z = XLEN'(ins[19:15]);
    end

    fmt_e            d_fmt;
    logic            d_ill;
    logic            d_pcrel;
    logic [XLEN-1:0] d_imm;
    logic [XLEN-1:0] d_target;

    always_comb begin
        d_fmt   = F_NONE;
        d_ill   = 1'b0;
        d_pcrel = 1'b0;
        case (op)
            OP_IMM, OP_LOAD, OP_JALR: d_fmt = F_I;
            OP_IMM32: begin
                if (IS64) d_fmt = F_I;
                else      d_ill = 1'b1;
            end
            OP_STORE: d_fmt = F_S;
            OP_BR: begin
                d_fmt   = F_B;
                d_pcrel = 1'b1;
            end
            OP_LUI: d_fmt = F_U;
            OP_AUIPC: begin
                d_fmt   = F_U;
                d_pcrel = 1'b1;
            end
            OP_JAL: begin
                d_fmt   = F_J;
                d_pcrel = 1'b1;
            end
            OP_SYS: begin
                if (f3 == 3'b100)    d_ill = 1'b1;
                else if (f3[2])      d_fmt = F_Z;
            end
            OP_REG, OP_FENCE: d_fmt = F_NONE;
            OP_REG32: begin
                if (!IS64) d_ill = 1'b1;
            end
            default: d_ill = 1'b1;
        endcase
        if (ins[1:0] != 2'b11) d_ill = 1'b1;
        if (d_ill) begin
            d_fmt   = F_NONE;
            d_pcrel = 1'b0;
        end
    end

    always_comb begin
        d_imm = '0;
        case (d_fmt)
            F_I:     d_imm = imm_i;
            F_S:     d_imm = imm_s;
            F_B:     d_imm = imm_b;
            F_U:     d_imm = imm_u;
            F_J:     d_imm = imm_j;
            F_Z:     d_imm = imm_z;
            default: d_imm = '0;
        endcase
    end

    // Wraps modulo 2^XLEN; JALR stays 0 since its base is a register.
    assign d_target = d_pcrel ? bus.pc + d_imm : '0;

    logic in_hs;
    logic out_hs;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign in_hs        = bus.in_valid && bus.in_ready;
    assign out_hs       = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.imm_out   <= '0;
            bus.fmt       <= F_NONE;
            bus.target    <= '0;
            bus.illegal   <= 1'b0;
        end else if (in_hs) begin
            bus.out_valid <= 1'b1;
            bus.imm_out   <= d_imm;
            bus.fmt       <= d_fmt;
            bus.target    <= d_target;
            bus.illegal   <= d_ill;
        end else if (out_hs) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef IMM_GEN_PIPE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            decoded_count <= '0;
            illegal_count <= '0;
        end else if (in_hs) begin
            if (decoded_count != '1)
                decoded_count <= decoded_count + 32'd1;
            if (d_ill && illegal_count != '1)
                illegal_count <= illegal_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stream,
// checked against a queue-based decode model plus literal expectations.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [63:0] pc;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64)) b64 ();

    assign b32.in_valid    = in_valid;
    assign b32.instruction = instr;
    assign b32.pc          = pc[31:0];
    assign b32.out_ready   = out_ready;
    assign b64.in_valid    = in_valid;
    assign b64.instruction = instr;
    assign b64.pc          = pc;
    assign b64.out_ready   = out_ready;

`ifdef IMM_GEN_PIPE_STATS_EN
    logic [31:0] dc32, dc64;
    logic [15:0] ic32, ic64;
`endif

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk),
        .rst(rst),
        .bus(b32.slave)
`ifdef IMM_GEN_PIPE_STATS_EN
        ,
        .decoded_count(dc32),
        .illegal_count(ic32)
`endif
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk),
        .rst(rst),
        .bus(b64.slave)
`ifdef IMM_GEN_PIPE_STATS_EN
        ,
        .decoded_count(dc64),
        .illegal_count(ic64)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Two's-complement reinterpretation of a bits-wide unsigned value.
    function automatic longint sx(input longint raw, input int bits);
        longint h;
        h = longint'(1) << (bits - 1);
        return (raw >= h) ? raw - 2 * h : raw;
    endfunction

    function automatic void model(input logic [31:0] ins,
                                  input logic [63:0] p, input bit x64,
                                  output logic [63:0] imm,
                                  output logic [2:0] f,
                                  output logic [63:0] tgt,
                                  output logic ill);
        longint v;
        bit tg;
        logic [63:0] m;
        v = 0; f = 3'd0; ill = 1'b0; tg = 1'b0;
        m = x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: begin
                f = 3'd1; v = sx(longint'(ins[31:20]), 12);
            end
            7'h1B: begin
                if (x64) begin f = 3'd1; v = sx(longint'(ins[31:20]), 12); end
                else ill = 1'b1;
            end
            7'h23: begin
                f = 3'd2; v = sx(longint'({ins[31:25], ins[11:7]}), 12);
            end
            7'h63: begin
                f = 3'd3; tg = 1'b1;
                v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                       + longint'(ins[30:25]) * 32
                       + longint'(ins[11:8]) * 2, 13);
            end
            7'h37, 7'h17: begin
                f = 3'd4; tg = (ins[6:0] == 7'h17);
                v = sx(longint'(ins[31:12]) * 4096, 32);
            end
            7'h6F: begin
                f = 3'd5; tg = 1'b1;
                v = sx(longint'(ins[31]) * 1048576
                       + longint'(ins[19:12]) * 4096
                       + longint'(ins[20]) * 2048
                       + longint'(ins[30:21]) * 2, 21);
            end
            7'h73: begin
                if (ins[14:12] >= 3'd5) begin f = 3'd6; v = longint'(ins[19:15]); end
                else if (ins[14:12] == 3'd4) ill = 1'b1;
            end
            7'h33, 7'h0F: f = 3'd0;
            7'h3B: if (!x64) ill = 1'b1;
            default: ill = 1'b1;
        endcase
        if (ill) begin f = 3'd0; v = 0; tg = 1'b0; end
        imm = 64'(v) & m;
        tgt = tg ? ((p + 64'(v)) & m) : 64'd0;
    endfunction

    typedef struct {
        logic [63:0] i32, t32, i64, t64;
        logic [2:0]  f32, f64;
        logic        l32, l64;
    } exp_t;

    exp_t q[$];

    always @(posedge clk) begin
        exp_t e;
        bit ir;
        bit ohs;
        if (rst) begin
            q.delete();
        end else begin
            ir  = (q.size() == 0) || out_ready;
            ohs = (q.size() != 0) && out_ready;
            if (ohs) void'(q.pop_front());
            if (in_valid && ir) begin
                model(instr, {32'd0, pc[31:0]}, 1'b0, e.i32, e.f32, e.t32, e.l32);
                model(instr, pc, 1'b1, e.i64, e.f64, e.t64, e.l64);
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid32", b32.out_valid, q.size() != 0);
            chk("valid64", b64.out_valid, q.size() != 0);
            chk("ready32", b32.in_ready, (q.size() == 0) || out_ready);
            chk("ready64", b64.in_ready, (q.size() == 0) || out_ready);
            if (q.size() != 0) begin
                chk("imm32", b32.imm_out, q[0].i32);
                chk("fmt32", b32.fmt, q[0].f32);
                chk("tgt32", b32.target, q[0].t32);
                chk("ill32", b32.illegal, q[0].l32);
                chk("imm64", b64.imm_out, q[0].i64);
                chk("fmt64", b64.fmt, q[0].f64);
                chk("tgt64", b64.target, q[0].t64);
                chk("ill64", b64.illegal, q[0].l64);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [63:0] p);
        instr = ins;
        pc = p;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_v32"}, b32.out_valid, 0);
        chk({tag, "_imm32"}, b32.imm_out, 0);
        chk({tag, "_fmt32"}, b32.fmt, 0);
        chk({tag, "_tgt32"}, b32.target, 0);
        chk({tag, "_ill32"}, b32.illegal, 0);
        chk({tag, "_v64"}, b64.out_valid, 0);
        chk({tag, "_imm64"}, b64.imm_out, 0);
`ifdef IMM_GEN_PIPE_STATS_EN
        chk({tag, "_dc"}, dc32, 0);
        chk({tag, "_ic"}, ic32, 0);
`endif
    endtask

    logic [31:0] vec_i[16] = '{
        32'hFE112E23, 32'h7FDFF0EF, 32'h8000006F, 32'h3005D073,
        32'h300FF073, 32'h30001073, 32'h30004073, 32'h00000073,
        32'h0000000F, 32'h002081B3, 32'h002081BB, 32'h00001097,
        32'h000080E7, 32'h00012083, 32'h00000001, 32'h7FF00FE3
    };
    logic [63:0] vec_p[16] = '{
        64'h0, 64'h1000, 64'h10, 64'h0,
        64'h0, 64'h0, 64'h0, 64'h0,
        64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_F000,
        64'h2000, 64'h0, 64'h0, 64'h0000_0000_FFFF_F800
    };

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        instr = 32'd0; pc = 64'd0;
        step();
        step();
        chk_zero("reset");
        rst = 1'b0;
        chk_en = 1'b1;

        drive(32'hFFF00093, 64'h0);
        chk("addi_v", b32.out_valid, 1);
        chk("addi_fmt", b32.fmt, 1);
        chk("addi_imm", b32.imm_out, 64'hFFFF_FFFF);
        chk("addi_ill", b32.illegal, 0);

        drive(32'hFE000EE3, 64'h100);
        chk("beq_fmt", b32.fmt, 3);
        chk("beq_imm", b32.imm_out, 64'hFFFF_FFFC);
        chk("beq_tgt", b32.target, 64'hFC);

        drive(32'hFE000EE3, 64'h0);
        chk("beq_wrap32", b32.target, 64'hFFFF_FFFC);
        chk("beq_wrap64", b64.target, 64'hFFFF_FFFF_FFFF_FFFC);

        drive(32'h800000B7, 64'h0);
        chk("lui64_imm", b64.imm_out, 64'hFFFF_FFFF_8000_0000);
        chk("lui64_fmt", b64.fmt, 4);

        drive(32'h0000001B, 64'h0);
        chk("addiw32_ill", b32.illegal, 1);
        chk("addiw64_fmt", b64.fmt, 1);

        foreach (vec_i[k]) drive(vec_i[k], vec_p[k]);
        step();

        instr = 32'h123450B7; pc = 64'h0;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        instr = 32'h00100093;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_ready", b32.in_ready, 0);
            chk("bp_valid", b32.out_valid, 1);
            chk("bp_imm", b32.imm_out, 64'h1234_5000);
        end
        out_ready = 1'b1;
        step();
        chk("b2b_valid", b32.out_valid, 1);
        chk("b2b_imm", b32.imm_out, 64'h1);
        in_valid = 1'b0;
        step();

        instr = 32'hFE000EE3; pc = 64'h100; in_valid = 1'b1;
        step();
        out_ready = 1'b0;
        instr = 32'hFFF00093;
        rst = 1'b1;
        step();
        chk_zero("rst_flight");
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();

        in_valid = 1'b1;
        instr = 32'h00000013; step();
        instr = 32'h00000000; step();
        instr = 32'h00000093; step();
        instr = 32'h00000004; step();
        instr = 32'h00002083; step();
        in_valid = 1'b0;
        step();
`ifdef IMM_GEN_PIPE_STATS_EN
        chk("dc32", dc32, 5);
        chk("ic32", ic32, 2);
        chk("dc64", dc64, 5);
        chk("ic64", ic64, 2);
`endif
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  instruction/pc presented this cycle.
REQ-005 in_ready  output  1  block accepts input this cycle.
REQ-006 instruction  input  32  raw RV instruction word.
REQ-007 pc  input  XLEN  address of the instruction.
REQ-008 out_valid  output  1  output register holds a decoded result.
REQ-009 out_ready  input  1  consumer accepts the output this cycle.
REQ-010 imm_out  output  XLEN  sign- or zero-extended immediate.
REQ-011 fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).
REQ-012 target  output  XLEN  pc+imm for B, J, AUIPC; else 0.
REQ-013 illegal  output  1  opcode unrecognised or instruction[1:0] != 2'b11.

Function
REQ-014 Single registered output stage; latency 1 cycle from input handshake to out_valid.
REQ-015 Input handshake when in_valid && in_ready; output handshake when out_valid && out_ready.
REQ-016 in_ready = !out_valid || out_ready (combinational); full throughput of one per cycle under continuous out_ready.
REQ-017 On input handshake, all output registers load new decode; out_valid set to 1.
REQ-018 On output handshake without input handshake, out_valid clears to 0; data registers hold.
REQ-019 While out_valid && !out_ready, all outputs hold stable and in_ready = 0.
REQ-020 I fmt: opcodes 0010011, 0000011, 1100111, 0011011 (last only when XLEN=64, else illegal); imm = sext(instr[31:20]).
REQ-021 S fmt: opcode 0100011; imm = sext({instr[31:25], instr[11:7]}).
REQ-022 B fmt: opcode 1100011; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
REQ-023 U fmt: opcodes 0110111 (LUI), 0010111 (AUIPC); imm = sext({instr[31:12], 12'b0}) to XLEN.
REQ-024 J fmt: opcode 1101111; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
REQ-025 Z fmt: opcode 1110011 with funct3 in {101,110,111}; imm = zero-extended instr[19:15].
REQ-026 NONE fmt, illegal=0, imm=0: opcodes 0110011, 0111011 (XLEN=64 only), 0001111, and 1110011 with funct3 in {000,001,010,011}; funct3=100 under 1110011 is illegal.
REQ-027 Illegal: fmt=0, imm=0, target=0, illegal=1; still handshakes normally.
REQ-028 target = pc + imm modulo 2^XLEN (wrap-around, no carry out) for B, J, AUIPC; 0 for all others including JALR.
REQ-029 Simultaneous input and output handshake in one cycle: new data loaded, out_valid remains 1.

Reset
REQ-030 rst high at a clock edge: out_valid=0, imm_out=0, fmt=0, target=0, illegal=0, counters=0; overrides any handshake that cycle.
REQ-031 During rst, in_ready=1 combinationally is permitted but no input is captured; an in-flight output is discarded.

Configuration
REQ-032 Macro IMM_GEN_PIPE_STATS_EN: when defined, adds outputs decoded_count (32) and illegal_count (16).
REQ-033 decoded_count increments on every input handshake; illegal_count increments on input handshakes decoding illegal; both saturate at all-ones; both reset to 0.
REQ-034 Without the macro, those ports and counters are absent; all other behaviour identical.

Verification
REQ-035 XLEN=32, instr 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, fmt=1, imm_out=0xFFFFFFFF, illegal=0.
REQ-036 instr 0xFE000EE3 (beq offset -4), pc 0x00000100 -> fmt=3, imm_out=0xFFFFFFFC, target=0x000000FC; pc 0x00000000 -> target=0xFFFFFFFC (wrap).
REQ-037 XLEN=64, instr 0x800000B7 (lui x1,0x80000) -> imm_out=0xFFFFFFFF80000000, fmt=4; instr 0x0000001B under XLEN=32 -> illegal=1.
REQ-038 Backpressure: accept 0x123450B7, hold out_ready=0 three cycles -> in_ready=0, imm_out=0x12345000 stable; raise out_ready with new in_valid -> back-to-back handshake, out_valid stays 1.
REQ-039 Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, all outputs 0, counters 0.
REQ-040 With IMM_GEN_PIPE_STATS_EN: 5 accepted words including 2 with instruction[1:0]=2'b00 -> decoded_count=5, illegal_count=2.
